// File: rtl/switch_egress_port.sv
// Egress port of a switch: accepts words addressed to this port into a small
// first-word-fall-through buffer and counts matched and dropped transfers.
module switch_egress_port #(
   parameter int unsigned PORT_ADDR_LENGTH = 32,
   parameter int unsigned DATA_WIDTH       = 64,
   parameter int unsigned FIFO_DEPTH       = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [PORT_ADDR_LENGTH-1:0]       port_addr,
   input  logic                              in_valid,
   input  logic [PORT_ADDR_LENGTH-1:0]       in_addr,
   input  logic [DATA_WIDTH-1:0]             in_data,
   output logic                              in_ready,
   output logic                              out_valid,
   output logic [DATA_WIDTH-1:0]             out_data,
   input  logic                              out_ready,
   output logic [$clog2(FIFO_DEPTH):0]       level,
   output logic [15:0]                       match_cnt,
   output logic [15:0]                       drop_cnt
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]         level_q;
   logic [15:0]           match_cnt_q, drop_cnt_q;

   logic in_xfer, addr_hit, push, pop;

   // Handshake is derived from registered level only, so full blocks input
   // even when the consumer is draining in the same cycle.
   always_comb begin
      in_ready  = (level_q != FULL_LEVEL);
      out_valid = (level_q != '0);
      out_data  = mem[rd_ptr_q];
      level     = level_q;
      match_cnt = match_cnt_q;
      drop_cnt  = drop_cnt_q;
      in_xfer   = in_valid && in_ready;
      addr_hit  = (in_addr == port_addr);
      push      = in_xfer && addr_hit;
      pop       = out_valid && out_ready;
   end

   // Payload storage carries no reset; validity lives in the control state.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         match_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            level_q <= level_q + 1'b1;
         end else if (pop && !push) begin
            level_q <= level_q - 1'b1;
         end
         if (push && (match_cnt_q != 16'hFFFF)) begin
            match_cnt_q <= match_cnt_q + 16'd1;
         end
         if (in_xfer && !addr_hit && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_switch_egress_port.sv
// Randomized and directed checks of switch_egress_port against a queue-based
// reference model of the port's buffer and counters.
module tb_switch_egress_port;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] port_addr;
   logic        in_valid;
   logic [31:0] in_addr;
   logic [63:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_ready;
   logic [2:0]  level;
   logic [15:0] match_cnt;
   logic [15:0] drop_cnt;

   switch_egress_port dut (
      .clk       (clk),
      .rst       (rst),
      .port_addr (port_addr),
      .in_valid  (in_valid),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .level     (level),
      .match_cnt (match_cnt),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   // Reference model
   logic [63:0] q[$];
   int unsigned exp_match = 0;
   int unsigned exp_drop  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("level", 64'(level), 64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'(q.size() != 4));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) chk("out_data", out_data, q[0]);
      chk("match_cnt", 64'(match_cnt), 64'(exp_match));
      chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
   endtask

   // One clock: drive inputs, predict from pre-edge model state, sample after edge.
   task automatic cycle(input logic v, input logic [31:0] a, input logic [63:0] d,
                        input logic ordy, input bit do_check);
      bit acc, hit, popd;
      in_valid  = v;
      in_addr   = a;
      in_data   = d;
      out_ready = ordy;
      acc  = v && (q.size() != 4);
      hit  = (a == port_addr);
      popd = ordy && (q.size() != 0);
      @(posedge clk);
      #1;
      if (popd) void'(q.pop_front());
      if (acc && hit) begin
         q.push_back(d);
         if (exp_match < 65535) exp_match++;
      end else if (acc) begin
         if (exp_drop < 65535) exp_drop++;
      end
      if (do_check) check_all();
   endtask

   task automatic mid_reset();
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_match", 64'(match_cnt), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      q.delete();
      exp_match = 0;
      exp_drop  = 0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_hold_level", 64'(level), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      port_addr = 32'h7;
      in_valid = 1'b0;
      in_addr = '0;
      in_data = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b0;

      // Single matched word
      cycle(1'b1, 32'h7, 64'hA5, 1'b0, 1'b1);
      chk("first_data", out_data, 64'hA5);
      cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b1);

      // Mismatched word is consumed and dropped
      cycle(1'b1, 32'h8, 64'h55, 1'b0, 1'b1);
      chk("drop_one", 64'(drop_cnt), 64'd1);

      // Fill while stalled, fifth word held off until space frees
      for (int i = 1; i <= 4; i++) cycle(1'b1, 32'h7, 64'(i), 1'b0, 1'b1);
      cycle(1'b1, 32'h7, 64'd5, 1'b0, 1'b1);
      chk("full_level", 64'(level), 64'd4);
      n = 0;
      while (exp_match < 6 && n < 10) begin
         cycle(1'b1, 32'h7, 64'd5, 1'b1, 1'b1);
         n++;
      end
      chk("fifth_accepted", 64'(exp_match), 64'd6);
      n = 0;
      while (q.size() != 0 && n < 10) begin
         cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b1);
         n++;
      end
      chk("drained", 64'(level), 64'd0);

      // Simultaneous push and pop at level 2
      cycle(1'b1, 32'h7, 64'h10, 1'b0, 1'b1);
      cycle(1'b1, 32'h7, 64'h11, 1'b0, 1'b1);
      cycle(1'b1, 32'h7, 64'h12, 1'b1, 1'b1);
      chk("pushpop_level", 64'(level), 64'd2);
      chk("pushpop_head", out_data, 64'h11);
      cycle(1'b1, 32'h7, 64'h13, 1'b0, 1'b1);

      // Reset mid-stream at level 3, then post-reset word is first out
      mid_reset();
      cycle(1'b1, 32'h7, 64'hBEEF, 1'b0, 1'b1);
      chk("post_rst_head", out_data, 64'hBEEF);
      cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b1);

      // Randomized traffic with occasional port address changes
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         if ($urandom_range(0, 19) == 0) port_addr = $urandom_range(0, 3);
         case ($urandom_range(0, 2))
            0:       a = port_addr;
            1:       a = port_addr ^ 32'h1;
            default: a = $urandom;
         endcase
         cycle(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
               1'($urandom_range(0, 2) != 0), 1'b1);
      end

      // Drop counter saturation
      mid_reset();
      port_addr = 32'h7;
      for (int i = 0; i < 65540; i++) cycle(1'b1, 32'h8, 64'h0, 1'b0, 1'b0);
      in_valid = 1'b0;
      check_all();
      chk("drop_sat", 64'(drop_cnt), 64'hFFFF);
      chk("match_zero", 64'(match_cnt), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/switch_egress_port.md
SWITCH_EGRESS_PORT -- requirements
Module: switch_egress_port

Interface
REQ-001 SHALL have parameter PORT_ADDR_LENGTH, default 32, width of the destination port address.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, payload width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, egress buffer entries; power of two, minimum 2.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port port_addr  input  PORT_ADDR_LENGTH  address owned by this port; quasi-static.
REQ-007 SHALL have port in_valid  input  1  switch-side word valid.
REQ-008 SHALL have port in_addr  input  PORT_ADDR_LENGTH  destination address of the word.
REQ-009 SHALL have port in_data  input  DATA_WIDTH  payload.
REQ-010 SHALL have port in_ready  output  1  port can accept a word.
REQ-011 SHALL have port out_valid  output  1  head-of-buffer word valid.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  head-of-buffer payload.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the head word.
REQ-014 SHALL have port level  output  $clog2(FIFO_DEPTH)+1  buffered word count.
REQ-015 SHALL have port match_cnt  output  16  accepted-and-matched word count.
REQ-016 SHALL have port drop_cnt  output  16  accepted-but-mismatched word count.

Function
REQ-017 SHALL define input transfer as in_valid && in_ready in one cycle; output transfer as out_valid && out_ready.
REQ-018 SHALL drive in_ready = (level != FIFO_DEPTH), combinationally from registered state only; no dependence on out_ready.
REQ-019 SHALL push in_data on an input transfer with in_addr == port_addr (full-width compare).
REQ-020 SHALL consume but discard a word on an input transfer with in_addr != port_addr; buffer unchanged.
REQ-021 SHALL present a pushed word on out_valid/out_data at the next rising edge (1-cycle latency), no combinational in-to-out path.
REQ-022 SHALL keep buffer first-word-fall-through: out_data = oldest entry whenever out_valid = 1; out_valid = (level != 0).
REQ-023 SHALL hold out_data stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL pop the head on an output transfer; out_data undefined-but-stable when level = 0.
REQ-025 SHALL, on simultaneous push and pop, leave level unchanged and preserve order.
REQ-026 SHALL, when full, accept no input (in_ready = 0) even if out_ready = 1 that cycle; no bypass.
REQ-027 SHALL wrap read/write pointers modulo FIFO_DEPTH; level is the authoritative full/empty indicator.
REQ-028 SHALL increment match_cnt by 1 per matched input transfer, saturating at 16'hFFFF.
REQ-029 SHALL increment drop_cnt by 1 per mismatched input transfer, saturating at 16'hFFFF.
REQ-030 SHALL treat in_addr/in_data as don't-care when in_valid = 0; no counter or buffer change.
REQ-031 SHALL sample port_addr each cycle; a change affects only transfers on subsequent cycles.

Reset
REQ-032 SHALL, on rst = 1, immediately clear level, pointers, match_cnt, drop_cnt to 0; out_valid = 0, in_ready = 1 (after reset released, in_ready = 1 at first edge).
REQ-033 SHALL discard buffered words on reset mid-operation; no word emitted after reset that was pushed before it.
REQ-034 SHALL ignore in_valid and out_ready while rst = 1.
REQ-035 SHALL not reset buffer data storage; only control state.

Verification
REQ-036 SHALL cover: port_addr=0x0000_0007, one word addr 0x7 data 0xA5 -> out_valid next cycle, out_data=0xA5, match_cnt=1, drop_cnt=0.
REQ-037 SHALL cover: addr 0x8 with port_addr 0x7 -> in_ready stays 1, out_valid stays 0, drop_cnt=1.
REQ-038 SHALL cover: out_ready=0, five matched words offered -> first four accepted, level=4, in_ready=0, fifth held; then out_ready=1 -> data 1,2,3,4 in order, then fifth.
REQ-039 SHALL cover: level=2, push and pop same cycle -> level remains 2, output order intact.
REQ-040 SHALL cover: level=3 then rst pulse mid-stream -> out_valid=0, level=0, counters 0 immediately; post-reset word is first out.
REQ-041 SHALL cover: 65540 mismatched transfers -> drop_cnt saturates at 0xFFFF, match_cnt=0.
